// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Purpose:
//   Turns the raw PS/2 byte stream (scan_code / scan_code_valid) into clean
//   one-cycle move requests for the game logic.
//   - Understands the E0 (extended) and F0 (break) prefixes.
//   - Tracks which keys are held, so typematic auto-repeat produces no new
//     pulses.
//   - Maps WASD and the arrow keys onto one shared held bit per action.
//
// Ports:
//   CLOCK_50         in   1  system clock
//   resetn           in   1  asynchronous active-low reset (released synchronously)
//   scan_code        in   8  received byte, qualified by scan_code_valid
//   scan_code_valid  in   1  one strobe per received byte (each high cycle = one byte)
//   left_pulse       out  1  one-cycle left request
//   right_pulse      out  1  one-cycle right request
//   rot_pulse        out  1  one-cycle rotate request
//   drop_pulse       out  1  one-cycle drop request
//   held             out  4  {drop,rot,right,left} currently-held flags
//   proto_err        out  1  one-cycle strobe on prefix timeout or malformed prefix
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter logic [7:0]  KEY_LEFT   = 8'h1C,
  parameter logic [7:0]  KEY_RIGHT  = 8'h23,
  parameter logic [7:0]  KEY_ROT    = 8'h1D,
  parameter logic [7:0]  KEY_DROP   = 8'h1B,
  parameter logic [7:0]  EXT_LEFT   = 8'h6B,
  parameter logic [7:0]  EXT_RIGHT  = 8'h74,
  parameter logic [7:0]  EXT_ROT    = 8'h75,
  parameter logic [7:0]  EXT_DROP   = 8'h72,
  parameter logic [23:0] PREFIX_TO  = 24'd500000,
  parameter bit          REPEAT_SUP = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_code_valid,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       rot_pulse,
  output logic       drop_pulse,
  output logic [3:0] held,
  output logic       proto_err
);

  localparam logic [7:0]  CODE_E0  = 8'hE0;
  localparam logic [7:0]  CODE_F0  = 8'hF0;
  localparam logic [23:0] CNT_MAX  = 24'hFF_FFFF;
  // The timeout fires on the cycle the counter has already reached this value.
  localparam logic [23:0] TO_LAST  = PREFIX_TO - 24'd1;

  // Action order matches the held vector: bit0 left .. bit3 drop.
  localparam logic [31:0] NORM_CODES = {KEY_DROP, KEY_ROT, KEY_RIGHT, KEY_LEFT};
  localparam logic [31:0] EXT_CODES  = {EXT_DROP, EXT_ROT, EXT_RIGHT, EXT_LEFT};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches the core immediately, release is
  // aligned to the clock so no flop sees a release near its edge.
  // -------------------------------------------------------------------------
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Code lookup
  // -------------------------------------------------------------------------
  logic [3:0] norm_match;
  logic [3:0] ext_match;
  logic [3:0] norm_sel;
  logic [3:0] ext_sel;
  logic       norm_hit;
  logic       ext_hit;
  logic       is_e0;
  logic       is_f0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_match
    assign norm_match[gi] = (scan_code == NORM_CODES[gi*8 +: 8]);
    assign ext_match[gi]  = (scan_code == EXT_CODES[gi*8 +: 8]);
  end

  // Keep only the lowest matching action, so even a parameter set with
  // duplicate codes can never raise two pulses at once.
  assign norm_sel = norm_match & (~norm_match + 4'd1);
  assign ext_sel  = ext_match  & (~ext_match  + 4'd1);
  assign norm_hit = |norm_match;
  assign ext_hit  = |ext_match;
  assign is_e0    = (scan_code == CODE_E0);
  assign is_f0    = (scan_code == CODE_F0);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q,  state_d;
  logic [23:0] cnt_q,    cnt_d;
  logic [3:0]  held_q,   held_d;
  logic [3:0]  pulse_q,  pulse_d;
  logic        err_q,    err_d;

  always_ff @(posedge CLOCK_50 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      pulse_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  // A make pulses only when the action is not already held (auto-repeat
  // suppression); the held bit is set either way.
  function automatic logic [3:0] make_pulse(input logic [3:0] sel, input logic [3:0] cur_held);
    if (REPEAT_SUP) begin
      return sel & ~cur_held;
    end
    return sel;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    pulse_d = '0;
    err_d   = 1'b0;

    if (scan_code_valid) begin
      // Every byte restarts the prefix timeout, including a repeated E0.
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (is_e0) begin
            state_d = GOT_E0;
          end else if (is_f0) begin
            state_d = GOT_F0;
          end else if (norm_hit) begin
            pulse_d = make_pulse(norm_sel, held_q);
            held_d  = held_q | norm_sel;
          end
        end

        GOT_E0: begin
          if (is_f0) begin
            state_d = GOT_E0F0;
          end else if (is_e0) begin
            state_d = GOT_E0;
          end else begin
            state_d = IDLE;
            if (ext_hit) begin
              pulse_d = make_pulse(ext_sel, held_q);
              held_d  = held_q | ext_sel;
            end
          end
        end

        GOT_F0: begin
          state_d = IDLE;
          if (is_e0 || is_f0) begin
            err_d = 1'b1;
          end else if (norm_hit) begin
            held_d = held_q & ~norm_sel;
          end
        end

        GOT_E0F0: begin
          state_d = IDLE;
          if (is_e0 || is_f0) begin
            err_d = 1'b1;
          end else if (ext_hit) begin
            held_d = held_q & ~ext_sel;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      // Waiting for the byte that completes a prefix.
      if (cnt_q == TO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  assign left_pulse  = pulse_q[0];
  assign right_pulse = pulse_q[1];
  assign rot_pulse   = pulse_q[2];
  assign drop_pulse  = pulse_q[3];
  assign held        = held_q;
  assign proto_err   = err_q;

endmodule
